cache_path_arbiter: RTL and testbench
=====================================

# cache_path_arbiter

Clocked round-robin arbiter and sequencer for the three-output cache selector stage. It grants one of three requesters, holds the selector's one-hot `valid` lines stable, launches one token via `o_drive`, and waits for the asynchronous fire and free-next events before releasing the grant. It sits between the synchronous cache-replacement control logic and the click-based selector/pipeline fabric.

## Interface
Parameters:
- `SETUP_CYC`, default 2: cycles `o_valid` is held stable before `o_drive` rises (range 1–15).
- `TIMEOUT`, default 255: maximum cycles in WAIT_FIRE or WAIT_DONE before abort (range 1–65535).
- `CNT_W`, default 16: counter width; must satisfy `TIMEOUT < 2^CNT_W`.

Ports:
- `clk` input, 1 bit: single clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `i_req` input, 3 bits: requester request levels.
- `o_gnt` output, 3 bits: one-hot grant, held for the whole transaction.
- `o_valid` output, 3 bits: selector path-valid lines, equal to `o_gnt` from SETUP through WAIT_DONE.
- `o_drive` output, 1 bit: registered launch level to the selector sender.
- `i_fire` input, 1 bit: asynchronous selector fire pulse, width ≥ 2 `clk` periods.
- `i_free` input, 1 bit: asynchronous OR of downstream free-next, width ≥ 2 `clk` periods.
- `o_ack` output, 3 bits: one-cycle completion pulse to the granted requester.
- `o_err` output, 1 bit: one-cycle timeout pulse.
- `o_busy` output, 1 bit: high in any state except IDLE.

## Operation
- Async inputs `i_fire` and `i_free` each pass through a 2-FF synchronizer and a rising-edge detector, giving single-cycle `fire_p` and `free_p`.
- States:
  - IDLE → SETUP when `i_req != 0`. The grant goes to the first set bit at or after `ptr`, scanning upward modulo 3. `cnt` is cleared.
  - SETUP: `o_gnt` and `o_valid` are driven. Move to LAUNCH when `cnt == SETUP_CYC-1`.
  - LAUNCH: `o_drive` = 1. Move to WAIT_FIRE unconditionally after 1 cycle; `cnt` is cleared.
  - WAIT_FIRE: `o_drive` stays 1.
    - On `fire_p`: `o_drive` → 0, go to WAIT_DONE, clear `cnt`.
    - If `fire_p` and `free_p` arrive in the same cycle: `o_drive` → 0 and complete directly (go to DONE handling).
  - WAIT_DONE: on `free_p`, pulse `o_ack[g]`, set `ptr` = (g+1) mod 3, go to IDLE.
  - Timeout: in WAIT_FIRE or WAIT_DONE, when `cnt == TIMEOUT`, pulse `o_err`, drop `o_drive`/`o_gnt`/`o_valid`, go to IDLE. No `o_ack` is issued and `ptr` advances as if completed.
- After a grant, deasserting `i_req` is ignored; the transaction runs to completion or timeout.
- A `fire_p` outside WAIT_FIRE is discarded. A `free_p` outside WAIT_FIRE and WAIT_DONE is discarded.
- `ptr` is 2 bits and never takes value 3. Grant selection uses a 3-bit rotate of `i_req` by `ptr`.
- `cnt` saturates and does not wrap.

## Timing
- Reset values (all applied on the `rst` clock edge):
  - `o_gnt`, `o_valid`, `o_ack`: 3'b000.
  - `o_drive`, `o_err`: 0; `o_busy`: 0.
  - `ptr` = 0, state = IDLE; synchronizer flops cleared.
- `rst` asserted mid-transaction returns the block to IDLE on the next edge. Whatever the selector does afterwards is ignored.
- All outputs are registered.
- Request to `o_valid`: 1 cycle. `o_valid` to `o_drive`: exactly `SETUP_CYC` cycles.
- Async pulse to `fire_p`/`free_p`: 2–3 cycles.
- Minimum transaction: `SETUP_CYC` + 1 + 3 cycles.
- `o_ack` rises the cycle after `free_p` is detected. IDLE then re-arbitrates on the following cycle, giving 1 idle cycle between grants.
- `o_valid` never changes while `o_drive` = 1. It drops in the same cycle as `o_ack` or `o_err`.

## Structure
- Shared package `cache_ctrl_pkg` holds:
  - the state enum (IDLE, SETUP, LAUNCH, WAIT_FIRE, WAIT_DONE);
  - `N_PATH` = 3;
  - the rotate-priority function used by other cache arbiters.
- Sub-module `pulse_sync`: 2-FF synchronizer plus rising-edge detector, with ports `clk`, `rst`, `i_async`, `o_pulse`. It is instantiated twice, for `i_fire` and `i_free`.

## Test plan
- Reset with `i_req` = 3'b111 held: all outputs 0 during reset. After release: `o_gnt` = 001, `o_drive` rises 2 cycles after `o_valid`.
- `i_req` = 111 held, 4 transactions completed with fire/free pulses: grant order 001, 010, 100, 001 and matching `o_ack` pulses.
- `i_req` = 100 only, `i_req` dropped after grant: transaction still completes and `o_ack` = 100. `ptr` becomes 0, so a following 101 request grants 001.
- No `i_fire` after launch, `TIMEOUT` = 8: `o_err` pulses after 8 WAIT_FIRE cycles, all outputs clear, `o_ack` never asserts.
- `i_fire` and `i_free` raised on the same edge: single `o_ack`, no transition into WAIT_DONE.
- `rst` pulsed during WAIT_DONE: back in IDLE with `ptr` = 0, and a later stray `i_free` pulse produces no `o_ack`.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state encoding, path count and rotate-priority pick for cache arbiters.
package cache_ctrl_pkg;

    localparam int N_PATH = 3;

    typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT_FIRE, WAIT_DONE} state_t;

    // Index of the first set bit at or after ptr, scanning upward modulo N_PATH.
    function automatic logic [1:0] rr_pick(input logic [N_PATH-1:0] req, input logic [1:0] ptr);
        logic [5:0] dbl;
        logic [2:0] rot;
        logic [1:0] off;
        logic [2:0] sum;
        dbl = {req, req} >> ptr;
        rot = dbl[2:0];
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
        sum = {1'b0, ptr} + {1'b0, off};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// pulse_sync: 2-FF synchronizer with rising-edge detector producing a one-cycle pulse.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic [2:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[1:0], i_async};
    end

    assign o_pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/cache_path_arbiter.sv
// cache_path_arbiter: round-robin grant of three requesters and token launch sequencing
// towards the click-based selector, completing on async fire/free-next events.
module cache_path_arbiter
    import cache_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PATH-1:0] i_req,
    output logic [N_PATH-1:0] o_gnt,
    output logic [N_PATH-1:0] o_valid,
    output logic              o_drive,
    input  logic              i_fire,
    input  logic              i_free,
    output logic [N_PATH-1:0] o_ack,
    output logic              o_err,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        ptr;
    logic [1:0]        gi;
    logic [1:0]        pick;
    logic [1:0]        ptr_nxt;
    logic              fire_p;
    logic              free_p;
    logic              done;
    logic              abort;

    pulse_sync u_fire (.clk(clk), .rst(rst), .i_async(i_fire), .o_pulse(fire_p));
    pulse_sync u_free (.clk(clk), .rst(rst), .i_async(i_free), .o_pulse(free_p));

    assign pick    = rr_pick(i_req, ptr);
    assign ptr_nxt = (gi == 2'd2) ? 2'd0 : gi + 2'd1;
    // Simultaneous fire and free in WAIT_FIRE completes without visiting WAIT_DONE.
    assign done    = free_p && (state == WAIT_DONE || (state == WAIT_FIRE && fire_p));
    assign abort   = cnt == TO_LAST && ((state == WAIT_FIRE && !fire_p) || (state == WAIT_DONE && !free_p));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= 2'd0;
            gi      <= 2'd0;
            o_gnt   <= '0;
            o_valid <= '0;
            o_ack   <= '0;
            o_drive <= 1'b0;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_ack <= done ? o_gnt : '0;
            o_err <= abort;
            cnt   <= (cnt == '1) ? cnt : cnt + 1'b1;
            if (done || abort) begin
                state   <= IDLE;
                ptr     <= ptr_nxt;
                o_gnt   <= '0;
                o_valid <= '0;
                o_drive <= 1'b0;
                o_busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (|i_req) begin
                        state   <= SETUP;
                        gi      <= pick;
                        o_gnt   <= 3'b001 << pick;
                        o_valid <= 3'b001 << pick;
                        o_busy  <= 1'b1;
                        cnt     <= '0;
                    end
                    SETUP: if (cnt == SETUP_LAST) begin
                        state   <= LAUNCH;
                        o_drive <= 1'b1;
                    end
                    LAUNCH: begin
                        state <= WAIT_FIRE;
                        cnt   <= '0;
                    end
                    WAIT_FIRE: if (fire_p) begin
                        state   <= WAIT_DONE;
                        o_drive <= 1'b0;
                        cnt     <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cache_path_arbiter.sv
// tb_cache_path_arbiter: directed transaction table, randomized transactions and reset
// corner cases checked against a transaction-level round-robin model.
module tb_cache_path_arbiter;

    localparam int SETUP_CYC = 2;
    localparam int TO_CYC    = 8;

    logic       clk;
    logic       rst;
    logic [2:0] i_req;
    logic [2:0] o_gnt;
    logic [2:0] o_valid;
    logic       o_drive;
    logic       i_fire;
    logic       i_free;
    logic [2:0] o_ack;
    logic       o_err;
    logic       o_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    typedef struct {
        logic [2:0] req;
        int         mode;
        bit         drop;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[9];

    cache_path_arbiter #(.SETUP_CYC(SETUP_CYC), .TIMEOUT(TO_CYC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .o_gnt(o_gnt), .o_valid(o_valid),
        .o_drive(o_drive), .i_fire(i_fire), .i_free(i_free), .o_ack(o_ack),
        .o_err(o_err), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_fire();
        i_fire = 1'b1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                i_fire = 1'b0;
            end
        join_none
    endtask

    task automatic pulse_free();
        i_free = 1'b1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                i_free = 1'b0;
            end
        join_none
    endtask

    function automatic logic [2:0] model_gnt(input logic [2:0] req, input int p);
        for (int k = 0; k < 3; k++)
            if (req[(p + k) % 3]) return 3'b001 << ((p + k) % 3);
        return 3'b000;
    endfunction

    function automatic int model_next_ptr(input logic [2:0] g);
        return g == 3'b001 ? 1 : g == 3'b010 ? 2 : 0;
    endfunction

    // mode 0: fire then free, 1: fire and free together, 2: no fire (timeout)
    task automatic run_txn(input logic [2:0] req, input int mode, input bit drop, input logic [2:0] exp);
        int n;
        i_req = req;
        n = 0;
        while (o_gnt == 3'b000 && n < 10) begin tick(); n++; end
        check("grant", o_gnt, exp);
        check("valid_at_grant", o_valid, exp);
        check("busy", o_busy, 1);
        check("no_stale_pulse", {o_ack, o_err, o_drive}, 0);
        if (drop) i_req = 3'b000;
        n = 0;
        while (!o_drive && n < 10) begin
            check("valid_setup", o_valid, exp);
            tick();
            n++;
        end
        check("setup_len", n, SETUP_CYC);
        if (mode != 2) pulse_fire();
        if (mode == 1) pulse_free();
        n = 0;
        while (o_drive && n < 20) begin
            check("valid_hold", o_valid, exp);
            check("no_early_done", {o_ack, o_err}, 0);
            tick();
            n++;
        end
        check("drive_fell", o_drive, 0);
        if (mode == 2) begin
            check("timeout_len", n, TO_CYC + 2);
            check("err_pulse", o_err, 1);
            check("abort_clear", {o_gnt, o_valid, o_ack, o_busy}, 0);
        end else if (mode == 1) begin
            check("ack_same_cycle", o_ack, exp);
            check("same_clear", {o_gnt, o_valid, o_err, o_busy}, 0);
        end else begin
            check("wait_done_hold", {o_gnt, o_valid}, {exp, exp});
            check("wait_done_state", {o_ack, o_err, o_busy}, 1);
            pulse_free();
            n = 0;
            while (o_ack == 3'b000 && n < 12) begin
                check("hold_done", o_gnt, exp);
                tick();
                n++;
            end
            check("ack", o_ack, exp);
            check("done_clear", {o_gnt, o_valid, o_err, o_busy, o_drive}, 0);
        end
        m_ptr = model_next_ptr(exp);
    endtask

    initial begin
        logic [2:0] req;
        logic [2:0] exp;
        int mode;
        int n;
        vecs[0] = '{3'b111, 0, 1'b0, 3'b001};
        vecs[1] = '{3'b111, 0, 1'b0, 3'b010};
        vecs[2] = '{3'b111, 0, 1'b0, 3'b100};
        vecs[3] = '{3'b111, 0, 1'b0, 3'b001};
        vecs[4] = '{3'b100, 0, 1'b1, 3'b100};
        vecs[5] = '{3'b101, 0, 1'b0, 3'b001};
        vecs[6] = '{3'b110, 1, 1'b0, 3'b010};
        vecs[7] = '{3'b011, 2, 1'b0, 3'b001};
        vecs[8] = '{3'b001, 0, 1'b0, 3'b001};
        rst = 1'b1;
        i_req = 3'b111;
        i_fire = 1'b0;
        i_free = 1'b0;
        repeat (3) begin
            tick();
            check("reset_outputs", {o_gnt, o_valid, o_ack, o_drive, o_err, o_busy}, 0);
        end
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].req, vecs[i].mode, vecs[i].drop, vecs[i].exp);
        for (int i = 0; i < 16; i++) begin
            req  = 3'($urandom_range(1, 7));
            n    = $urandom_range(0, 5);
            mode = n < 3 ? 0 : n < 5 ? 1 : 2;
            run_txn(req, mode, 1'($urandom_range(0, 1)), model_gnt(req, m_ptr));
        end
        // Reset while waiting for free-next, then a stray free must be ignored.
        i_req = 3'b010;
        exp = model_gnt(i_req, m_ptr);
        n = 0;
        while (o_gnt == 3'b000 && n < 10) begin tick(); n++; end
        check("rst_case_grant", o_gnt, exp);
        n = 0;
        while (!o_drive && n < 10) begin tick(); n++; end
        pulse_fire();
        n = 0;
        while (o_drive && n < 20) begin tick(); n++; end
        check("rst_case_wait_done", {o_gnt, o_drive, o_busy}, {exp, 1'b0, 1'b1});
        rst = 1'b1;
        i_req = 3'b000;
        tick();
        check("mid_reset", {o_gnt, o_valid, o_ack, o_drive, o_err, o_busy}, 0);
        rst = 1'b0;
        m_ptr = 0;
        pulse_free();
        repeat (8) begin
            tick();
            check("stray_free", {o_ack, o_busy, o_gnt}, 0);
        end
        run_txn(3'b111, 0, 1'b0, 3'b001);
        i_req = 3'b000;
        tick();
        check("final_idle", {o_ack, o_busy, o_gnt, o_err}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
